// File: rtl/ifetch.sv
// Instruction fetch stage: issues one imem read at a time and holds the fetched word for IF/ID.
// Latency: a word appears on inst/valid the cycle after its ack; peak rate is one instruction per two cycles.
// Backpressure: en_ifid low parks the held word in HOLD; a branch squashes it and redirects the stream.
module ifetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        en_ifid,
  output logic [15:0] inst,
  output logic [15:0] pcinc,
  output logic        valid
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, SQUASH} state_t;

  state_t      state, state_d;
  logic [15:0] pc, pc_d;
  logic [15:0] old_addr, old_addr_d;
  logic [15:0] inst_d, pcinc_d;
  logic        valid_d;

  // State register; reset drops the request at once because imem_req decodes from state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
    end else begin
      state <= state_d;
    end
  end

  // Next-state, request outputs and next datapath values.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    old_addr_d = old_addr;
    inst_d     = inst;
    pcinc_d    = pcinc;
    valid_d    = valid;
    imem_req   = 1'b0;
    imem_addr  = 16'h0000;
    case (state)
      BOOT: begin
        // Branches are ignored here; the first fetch always starts at RESET_PC.
        state_d = FETCH;
      end
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        if (br_taken) begin
          pc_d    = br_target;
          valid_d = 1'b0;
          if (!imem_ack) begin
            // The request to pc is still in flight and must stay stable until acked.
            old_addr_d = pc;
            state_d    = SQUASH;
          end
        end else if (imem_ack) begin
          inst_d  = imem_rdata;
          pcinc_d = pc + 16'd1;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (br_taken) begin
          pc_d    = br_target;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (en_ifid) begin
          pc_d    = pc + 16'd1;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      SQUASH: begin
        // Finish the abandoned request; its data is thrown away.
        imem_req  = 1'b1;
        imem_addr = old_addr;
        if (br_taken) begin
          pc_d    = br_target;
          valid_d = 1'b0;
        end
        if (imem_ack) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Datapath registers, including the registered IF/ID-facing outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      old_addr <= 16'h0000;
      inst     <= 16'h0000;
      pcinc    <= 16'h0000;
      valid    <= 1'b0;
    end else begin
      pc       <= pc_d;
      old_addr <= old_addr_d;
      inst     <= inst_d;
      pcinc    <= pcinc_d;
      valid    <= valid_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: scoreboard of expected delivered words plus cycle-accurate request checks.
// Inputs are driven just after each falling edge and outputs sampled at the next falling edge.
// A second instance with RESET_PC=16'hFFFF covers address wrap-around.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ack, br_taken, en_ifid, valid;
  logic [15:0] imem_addr, imem_rdata, br_target, inst, pcinc;

  logic        b_reset, b_req, b_ack, b_br, b_en, b_valid;
  logic [15:0] b_addr, b_rdata, b_tgt, b_inst, b_pcinc;

  typedef struct {
    logic [15:0] inst;
    logic [15:0] pcinc;
  } exp_t;

  exp_t sb[$];
  exp_t sb_b[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .br_taken(br_taken),
    .br_target(br_target), .en_ifid(en_ifid), .inst(inst), .pcinc(pcinc), .valid(valid)
  );

  ifetch #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .reset(b_reset), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(b_ack), .imem_rdata(b_rdata), .br_taken(b_br),
    .br_target(b_tgt), .en_ifid(b_en), .inst(b_inst), .pcinc(b_pcinc), .valid(b_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // On each new live instruction, compare against the oldest expected entry.
  task automatic sb_check();
    exp_t e;
    if (valid === 1'b1 && prev_valid !== 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed inst %h with nothing expected", inst);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_inst", {16'h0, inst}, {16'h0, e.inst});
        chk("sb_pcinc", {16'h0, pcinc}, {16'h0, e.pcinc});
      end
    end
    prev_valid = valid;
  endtask

  task automatic cyc(input logic a, input logic [15:0] d, input logic b,
                     input logic [15:0] t, input logic e);
    imem_ack   = a;
    imem_rdata = d;
    br_taken   = b;
    br_target  = t;
    en_ifid    = e;
    @(negedge clk);
    imem_ack = 1'b0;
    br_taken = 1'b0;
    en_ifid  = 1'b0;
    sb_check();
  endtask

  task automatic cyc_b(input logic a, input logic [15:0] d, input logic e);
    exp_t x;
    logic pv;
    b_ack   = a;
    b_rdata = d;
    b_en    = e;
    pv      = b_valid;
    @(negedge clk);
    b_ack = 1'b0;
    b_en  = 1'b0;
    if (b_valid === 1'b1 && pv !== 1'b1) begin
      checks++;
      assert (sb_b.size() > 0) else begin
        errors++;
        $error("FAIL sbw_unexpected: observed inst %h with nothing expected", b_inst);
      end
      if (sb_b.size() > 0) begin
        x = sb_b.pop_front();
        chk("wrap_inst", {16'h0, b_inst}, {16'h0, x.inst});
        chk("wrap_pcinc", {16'h0, b_pcinc}, {16'h0, x.pcinc});
      end
    end
  endtask

  initial begin
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0; br_taken = 1'b0;
    br_target = 16'h0; en_ifid = 1'b0;
    b_reset = 1'b0; b_ack = 1'b0; b_rdata = 16'h0; b_br = 1'b0; b_tgt = 16'h0; b_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", {16'h0, imem_addr}, 32'h0);
    chk("rst_inst", {16'h0, inst}, 32'h0);
    chk("rst_pcinc", {16'h0, pcinc}, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);

    // Release; a branch during BOOT must be ignored
    reset = 1'b1;
    cyc(1'b0, 16'h0, 1'b1, 16'h0055, 1'b0);

    // Sequential fetch at peak rate, with a 5-cycle stall in HOLD at addr 4
    for (int a = 0; a < 7; a++) begin
      chk("f_req", {31'h0, imem_req}, 32'h1);
      chk("f_addr", {16'h0, imem_addr}, a);
      chk("f_valid", {31'h0, valid}, 32'h0);
      sb.push_back('{inst: 16'h1000 + 16'(a), pcinc: 16'(a) + 16'd1});
      cyc(1'b1, 16'h1000 + 16'(a), 1'b0, 16'h0, 1'b0);
      chk("h_req", {31'h0, imem_req}, 32'h0);
      if (a == 4) begin
        for (int k = 0; k < 5; k++) begin
          cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
          chk("stall_inst", {16'h0, inst}, 32'h1004);
          chk("stall_pcinc", {16'h0, pcinc}, 32'h0005);
          chk("stall_valid", {31'h0, valid}, 32'h1);
          chk("stall_req", {31'h0, imem_req}, 32'h0);
        end
      end
      cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    end

    // Branch in FETCH at addr 7 while ack is delayed
    chk("br_addr", {16'h0, imem_addr}, 32'h0007);
    cyc(1'b0, 16'h0, 1'b1, 16'h0040, 1'b0);
    repeat (2) begin
      chk("sq_req", {31'h0, imem_req}, 32'h1);
      chk("sq_addr", {16'h0, imem_addr}, 32'h0007);
      chk("sq_valid", {31'h0, valid}, 32'h0);
      cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    end
    chk("sq_addr_ack", {16'h0, imem_addr}, 32'h0007);
    cyc(1'b1, 16'hDEAD, 1'b0, 16'h0, 1'b0);
    chk("redir_addr", {16'h0, imem_addr}, 32'h0040);
    chk("redir_valid", {31'h0, valid}, 32'h0);

    // Branch in HOLD with en_ifid high: held word dropped
    sb.push_back('{inst: 16'h1040, pcinc: 16'h0041});
    cyc(1'b1, 16'h1040, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 16'h0100, 1'b1);
    chk("hbr_valid", {31'h0, valid}, 32'h0);
    chk("hbr_addr", {16'h0, imem_addr}, 32'h0100);

    // Branch with ack in FETCH: data discarded, refetch at target
    cyc(1'b1, 16'hBEEF, 1'b1, 16'h0200, 1'b0);
    chk("fba_addr", {16'h0, imem_addr}, 32'h0200);
    chk("fba_valid", {31'h0, valid}, 32'h0);

    // Repeated branches in SQUASH: old address held, latest target wins
    cyc(1'b0, 16'h0, 1'b1, 16'h0300, 1'b0);
    chk("sq2_addr", {16'h0, imem_addr}, 32'h0200);
    cyc(1'b0, 16'h0, 1'b1, 16'h0310, 1'b0);
    chk("sq3_addr", {16'h0, imem_addr}, 32'h0200);
    cyc(1'b1, 16'hBAD0, 1'b1, 16'h0320, 1'b0);
    chk("sqba_addr", {16'h0, imem_addr}, 32'h0320);

    // SQUASH ack without a new branch: fetch at the saved target
    cyc(1'b0, 16'h0, 1'b1, 16'h0330, 1'b0);
    chk("sq4_addr", {16'h0, imem_addr}, 32'h0320);
    cyc(1'b1, 16'hBAD1, 1'b0, 16'h0, 1'b0);
    chk("sqa_addr", {16'h0, imem_addr}, 32'h0330);
    sb.push_back('{inst: 16'h1330, pcinc: 16'h0331});
    cyc(1'b1, 16'h1330, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    chk("post_addr", {16'h0, imem_addr}, 32'h0331);

    // Asynchronous reset while SQUASH has a request outstanding
    cyc(1'b0, 16'h0, 1'b1, 16'h0400, 1'b0);
    chk("pre_rst_req", {31'h0, imem_req}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    chk("arst_addr", {16'h0, imem_addr}, 32'h0);
    chk("arst_inst", {16'h0, inst}, 32'h0);
    chk("arst_pcinc", {16'h0, pcinc}, 32'h0);
    chk("arst_valid", {31'h0, valid}, 32'h0);
    prev_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 16'hDEAD, 1'b0, 16'h0, 1'b0);
    chk("rel_req", {31'h0, imem_req}, 32'h1);
    chk("rel_addr", {16'h0, imem_addr}, 32'h0000);
    chk("rel_valid", {31'h0, valid}, 32'h0);
    sb.push_back('{inst: 16'h1000, pcinc: 16'h0001});
    cyc(1'b1, 16'h1000, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    chk("sb_drain", sb.size(), 32'h0);

    // Wrap-around instance starting at 16'hFFFF
    b_reset = 1'b1;
    cyc_b(1'b0, 16'h0, 1'b0);
    chk("w_addr0", {16'h0, b_addr}, 32'hFFFF);
    sb_b.push_back('{inst: 16'hAAAA, pcinc: 16'h0000});
    cyc_b(1'b1, 16'hAAAA, 1'b0);
    cyc_b(1'b0, 16'h0, 1'b1);
    chk("w_req1", {31'h0, b_req}, 32'h1);
    chk("w_addr1", {16'h0, b_addr}, 32'h0000);
    sb_b.push_back('{inst: 16'hBBBB, pcinc: 16'h0001});
    cyc_b(1'b1, 16'hBBBB, 1'b0);
    chk("w_drain", sb_b.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
